// File: rtl/run_pattern_gen.sv
// Serial run-pattern transmitter: emits N1 runs of four 1s then N0 runs of four 0s
// per accepted start, and shows the latched counts on two 7-segment outputs.
module run_pattern_gen (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] n1,
  input  logic [3:0] n0,
  output logic       ser,
  output logic       ser_en,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg1,
  output logic [6:0] seg0
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONES  = 2'd1,
    ZEROS = 2'd2
  } state_t;

  state_t     state_r, next_s;
  logic [3:0] r1_r, r0_r, r1_s, r0_s;
  logic [3:0] lat1_r, lat0_r, lat1_s, lat0_s;
  logic [1:0] bc_r, bc_s;
  logic       done_s;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1100111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Next-state and counter update logic
  always_comb begin
    next_s = state_r;
    r1_s   = r1_r;
    r0_s   = r0_r;
    bc_s   = bc_r;
    lat1_s = lat1_r;
    lat0_s = lat0_r;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          lat1_s = clamp9(n1);
          lat0_s = clamp9(n0);
          r1_s   = clamp9(n1);
          r0_s   = clamp9(n0);
          bc_s   = 2'd0;
          if (clamp9(n1) != 4'd0) begin
            next_s = ONES;
          end else if (clamp9(n0) != 4'd0) begin
            next_s = ZEROS;
          end else begin
            next_s = IDLE;
            done_s = 1'b1;
          end
        end else begin
          next_s = IDLE;
        end
      end
      ONES: begin
        bc_s = bc_r + 2'd1;
        if (bc_r == 2'd3) begin
          r1_s = r1_r - 4'd1;
          if (r1_r == 4'd1) begin
            if (r0_r != 4'd0) begin
              next_s = ZEROS;
            end else begin
              next_s = IDLE;
              done_s = 1'b1;
            end
          end else begin
            next_s = ONES;
          end
        end else begin
          next_s = ONES;
        end
      end
      ZEROS: begin
        bc_s = bc_r + 2'd1;
        if (bc_r == 2'd3) begin
          r0_s = r0_r - 4'd1;
          if (r0_r == 4'd1) begin
            next_s = IDLE;
            done_s = 1'b1;
          end else begin
            next_s = ZEROS;
          end
        end else begin
          next_s = ZEROS;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State, counters and outputs; outputs follow the next state so the first bit
  // appears on the accepting edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      r1_r    <= 4'd0;
      r0_r    <= 4'd0;
      bc_r    <= 2'd0;
      lat1_r  <= 4'd0;
      lat0_r  <= 4'd0;
      ser     <= 1'b0;
      ser_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg1    <= 7'b0111111;
      seg0    <= 7'b0111111;
    end else begin
      state_r <= next_s;
      r1_r    <= r1_s;
      r0_r    <= r0_s;
      bc_r    <= bc_s;
      lat1_r  <= lat1_s;
      lat0_r  <= lat0_s;
      ser     <= (next_s == ONES);
      ser_en  <= (next_s != IDLE);
      busy    <= (next_s != IDLE);
      done    <= done_s;
      seg1    <= seg_enc(lat1_s);
      seg0    <= seg_enc(lat0_s);
    end
  end

endmodule
